text_frame_reader: RTL and testbench

- Character frame buffer plus raster scan-out reader.
- Write side accepts the frame_char/frame_x/frame_y/frame_we stream produced by the graph engines (e.g. the cycle detector's debug output) into a 40x30 cell store.
- Read side converts VGA pixel coordinates into glyph pixels through an external font ROM.
- Sits between the compute core and the VGA timing generator.

---
 rtl/text_frame_reader.sv | 187 ++++++++++++++++++
 tb/tb_text_frame_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_frame_reader.sv
// text_frame_reader: 40x30 character cell buffer with raster scan-out through an
// external registered font ROM. After reset (or a clear request) the buffer is swept
// to code 0, one cell per cycle, before host writes are accepted.
// Optional build macro TEXT_CURSOR_EN adds a blinking cursor on the last written cell.
module text_frame_reader #(
  parameter int COLS      = 40,
  parameter int ROWS      = 30,
  parameter int CHAR_BITS = 5,
  parameter int CELL_PX   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAR_BITS-1:0] frame_char,
  input  logic [5:0]           frame_x,
  input  logic [5:0]           frame_y,
  input  logic                 frame_we,
  input  logic                 clear_req,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 scan_valid,
  output logic [CHAR_BITS+3:0] font_addr,
  input  logic [15:0]          font_q,
  output logic                 pixel_on,
  output logic                 pixel_valid,
  output logic                 frame_ready,
  output logic                 wr_error
);

  localparam int          CELLS     = COLS * ROWS;
  localparam int          PX_BITS   = $clog2(CELL_PX);
  localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t state_q, state_d;
  logic [10:0] ptr_q, ptr_d;
  logic        wr_error_q, wr_error_d;

  logic [CHAR_BITS-1:0] mem_q [0:CELLS-1];
  logic                 mem_we;
  logic [10:0]          mem_waddr;
  logic [CHAR_BITS-1:0] mem_wdata;

  logic        wr_in_range;
  logic [10:0] wr_addr;

  // Scan pipeline: s1 = sampled coordinates, s2 = cell read, s3 = font word in flight.
  logic [10:0]          s1_addr_q, s1_addr_d;
  logic [3:0]           s1_row_q, s1_col_q, s2_col_q, s3_col_q;
  logic                 s1_valid_q, s2_valid_q, s3_valid_q;
  logic [CHAR_BITS+3:0] font_addr_q, font_addr_d;
  logic                 pixel_on_q, pixel_on_d;
  logic                 pixel_valid_q;
  logic                 cur_inv;

  assign wr_in_range = (frame_x < 6'(COLS)) && (frame_y < 6'(ROWS));
  assign wr_addr     = 11'(frame_y) * 11'(COLS) + 11'(frame_x);

  // Clear sweep / run control and write-port arbitration; a clear request beats a write.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_error_d = wr_error_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clear_req) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 11'd1;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (frame_we) begin
          if (wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = frame_char;
          end else begin
            wr_error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Cell store; the scan read below sees pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Scan datapath: cell lookup, font address hold when idle, glyph bit select.
  always_comb begin
    s1_addr_d   = 11'(vcount[9:PX_BITS]) * 11'(COLS) + 11'(hcount[9:PX_BITS]);
    font_addr_d = font_addr_q;
    if (s1_valid_q) font_addr_d = {mem_q[s1_addr_q], s1_row_q};
    pixel_on_d  = (font_q[4'd15 - s3_col_q] ^ cur_inv) & s3_valid_q;
  end

  // Control and scan pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      wr_error_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      s2_col_q      <= '0;
      s3_col_q      <= '0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s3_valid_q    <= 1'b0;
      font_addr_q   <= '0;
      pixel_on_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wr_error_q    <= wr_error_d;
      s1_addr_q     <= s1_addr_d;
      s1_row_q      <= vcount[3:0];
      s1_col_q      <= hcount[3:0];
      s2_col_q      <= s1_col_q;
      s3_col_q      <= s2_col_q;
      s1_valid_q    <= scan_valid;
      s2_valid_q    <= s1_valid_q;
      s3_valid_q    <= s2_valid_q;
      font_addr_q   <= font_addr_d;
      pixel_on_q    <= pixel_on_d;
      pixel_valid_q <= s3_valid_q;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic        wr_accept;
  logic [10:0] cursor_addr_q, cursor_addr_d;
  logic [4:0]  frame_cnt_q, frame_cnt_d;
  logic        s2_cur_q, s2_cur_d, s3_cur_q;

  assign wr_accept = (state_q == ST_RUN) && !clear_req && frame_we && wr_in_range;

  // Cursor tracking: last accepted write address and a frame counter bumped at pixel (0,0).
  always_comb begin
    cursor_addr_d = wr_accept ? wr_addr : cursor_addr_q;
    frame_cnt_d   = frame_cnt_q;
    if (scan_valid && hcount == 10'd0 && vcount == 10'd0) frame_cnt_d = frame_cnt_q + 5'd1;
    s2_cur_d      = (s1_addr_q == cursor_addr_q) && frame_cnt_q[4];
  end

  // Cursor registers; the invert flag rides the scan pipeline alongside the pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_addr_q <= '0;
      frame_cnt_q   <= '0;
      s2_cur_q      <= 1'b0;
      s3_cur_q      <= 1'b0;
    end else begin
      cursor_addr_q <= cursor_addr_d;
      frame_cnt_q   <= frame_cnt_d;
      s2_cur_q      <= s2_cur_d;
      s3_cur_q      <= s2_cur_q;
    end
  end

  assign cur_inv = s3_cur_q;
`else
  assign cur_inv = 1'b0;
`endif

  assign font_addr   = font_addr_q;
  assign pixel_on    = pixel_on_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_ready = (state_q == ST_RUN);
  assign wr_error    = wr_error_q;

endmodule

// File: tb/tb_text_frame_reader.sv
// Bench for text_frame_reader: directed scenarios plus randomized writes and a
// streaming random scan, checked against a cell-array / font-ROM reference model.
module tb_text_frame_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  frame_char;
  logic [5:0]  frame_x, frame_y;
  logic        frame_we, clear_req;
  logic [9:0]  hcount, vcount;
  logic        scan_valid;
  logic [8:0]  font_addr;
  logic [15:0] font_q;
  logic        pixel_on, pixel_valid, frame_ready, wr_error;

  text_frame_reader dut (
    .clk(clk), .reset(reset), .frame_char(frame_char), .frame_x(frame_x),
    .frame_y(frame_y), .frame_we(frame_we), .clear_req(clear_req),
    .hcount(hcount), .vcount(vcount), .scan_valid(scan_valid),
    .font_addr(font_addr), .font_q(font_q), .pixel_on(pixel_on),
    .pixel_valid(pixel_valid), .frame_ready(frame_ready), .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  // External font ROM: registered, one cycle of latency.
  logic [15:0] font_rom [0:511];
  always @(posedge clk) font_q <= font_rom[font_addr];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: character per cell, sticky error, ready flag.
  logic [4:0] model [0:1199];
  logic       model_err;
  logic       model_ready;

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cell_of(int h, int v);
    return (v / 16) * 40 + (h / 16);
  endfunction

  function automatic logic exp_pix(int h, int v);
    logic [15:0] w;
    w = font_rom[int'(model[cell_of(h, v)]) * 16 + (v % 16)];
    return w[15 - (h % 16)];
  endfunction

  function automatic logic [8:0] exp_faddr(int h, int v);
    return 9'(int'(model[cell_of(h, v)]) * 16 + (v % 16));
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 1200; i++) model[i] = 5'd0;
  endtask

  task automatic do_write(int x, int y, int c, bit clr = 1'b0);
    frame_x = 6'(x); frame_y = 6'(y); frame_char = 5'(c);
    frame_we = 1'b1; clear_req = clr;
    tick();
    frame_we = 1'b0; clear_req = 1'b0;
    if (model_ready) begin
      if (clr) model_ready = 1'b0;
      else if (x < 40 && y < 30) model[y * 40 + x] = 5'(c);
      else model_err = 1'b1;
    end
  endtask

  task automatic scan_one(int h, int v, output logic [8:0] fa, output logic po, output logic pv);
    hcount = 10'(h); vcount = 10'(v); scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    tick();
    fa = font_addr;
    tick(2);
    po = pixel_on;
    pv = pixel_valid;
  endtask

  task automatic wait_ready(string tag);
    int cnt;
    cnt = 0;
    while (!frame_ready && cnt < 1300) begin
      tick();
      cnt++;
    end
    check(tag, 16'(cnt), 16'd1200);
    model_zero();
    model_ready = 1'b1;
  endtask

  initial begin
    logic [8:0] fa;
    logic       po, pv;
    logic [1:0] q[$];
    logic [1:0] e;
    int h, v;
    bit sv;

    for (int i = 0; i < 512; i++) font_rom[i] = 16'($urandom);
    reset = 1'b1; frame_char = '0; frame_x = '0; frame_y = '0;
    frame_we = 1'b0; clear_req = 1'b0; hcount = '0; vcount = '0; scan_valid = 1'b0;
    model_err = 1'b0; model_ready = 1'b0;
    tick(3);

    check("rst_pixel_on", 16'(pixel_on), 16'd0);
    check("rst_pixel_valid", 16'(pixel_valid), 16'd0);
    check("rst_frame_ready", 16'(frame_ready), 16'd0);
    check("rst_wr_error", 16'(wr_error), 16'd0);
    check("rst_font_addr", 16'(font_addr), 16'd0);

    reset = 1'b0;
    wait_ready("init_clear_len");

    scan_one(200, 100, fa, po, pv);
    check("cleared_char", 16'(fa[8:4]), 16'd0);

    // Glyph path: char 7 at (3,2), row 5.
    do_write(3, 2, 7);
    font_rom[9'h075] = 16'h8000;
    scan_one(48, 37, fa, po, pv);
    check("glyph_faddr", 16'(fa), 16'h075);
    check("glyph_pix_left", 16'(po), 16'd1);
    check("glyph_valid", 16'(pv), 16'd1);
    scan_one(49, 37, fa, po, pv);
    check("glyph_pix_next", 16'(po), 16'd0);

    // Last cell and out-of-range writes.
    do_write(39, 29, 31);
    scan_one(639, 479, fa, po, pv);
    check("last_cell_faddr", 16'(fa), 16'h1FF);
    check("last_cell_pix", 16'(po), 16'(exp_pix(639, 479)));
    do_write(0, 0, 9);
    do_write(40, 0, 3);
    check("wr_error_x", 16'(wr_error), 16'(model_err));
    do_write(0, 30, 4);
    check("wr_error_y", 16'(wr_error), 16'd1);
    scan_one(0, 0, fa, po, pv);
    check("cell00_kept", 16'(fa[8:4]), 16'd9);
    scan_one(0, 16, fa, po, pv);
    check("cell01_kept", 16'(fa[8:4]), 16'(model[40]));

    // Same-cycle scan read and write of one cell: old contents first.
    hcount = 10'd160; vcount = 10'd160; scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    frame_x = 6'd10; frame_y = 6'd10; frame_char = 5'd21; frame_we = 1'b1;
    tick();
    frame_we = 1'b0;
    check("collide_old", 16'(fa[8:4] & 5'd0) | 16'(font_addr[8:4]), 16'(model[410]));
    model[410] = 5'd21;
    tick(2);
    scan_one(160, 160, fa, po, pv);
    check("collide_new", 16'(fa[8:4]), 16'd21);

    // Random writes, some out of range.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0)
        do_write($urandom_range(0, 45), $urandom_range(0, 35), $urandom_range(0, 31));
      else
        do_write($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 31));
    end
    check("rand_wr_error", 16'(wr_error), 16'(model_err));
    tick(2);

    // Streaming random scan, one pixel per clock.
    for (int i = 0; i < 300; i++) begin
      h = $urandom_range(0, 639);
      v = $urandom_range(0, 479);
      sv = ($urandom_range(0, 4) != 0);
      hcount = 10'(h); vcount = 10'(v); scan_valid = sv;
      q.push_back(sv ? {1'b1, exp_pix(h, v)} : 2'b00);
      tick();
      if (q.size() > 3) begin
        e = q.pop_front();
        check("stream_pix", 16'({pixel_valid, pixel_on}), 16'(e));
      end
    end
    scan_valid = 1'b0;
    repeat (3) begin
      tick();
      e = q.pop_front();
      check("stream_pix", 16'({pixel_valid, pixel_on}), 16'(e));
    end
    h = $urandom_range(0, 639);
    v = $urandom_range(0, 479);
    scan_one(h, v, fa, po, pv);
    check("rand_faddr", 16'(fa), 16'(exp_faddr(h, v)));

    // Clear request together with a write: clear wins.
    do_write(5, 5, 12);
    do_write(5, 5, 13, 1'b1);
    check("clear_ready_drop", 16'(frame_ready), 16'd0);
    wait_ready("clear_req_len");
    scan_one(80, 80, fa, po, pv);
    check("cell55_cleared", 16'(fa[8:4]), 16'd0);
    check("wr_error_sticky", 16'(wr_error), 16'd1);

    // Asynchronous reset in the middle of a clear sweep.
    do_write(39, 29, 17);
    scan_one(639, 479, fa, po, pv);
    do_write(0, 0, 0, 1'b1);
    tick(600);
    #2 reset = 1'b1;
    #1;
    check("async_wr_error", 16'(wr_error), 16'd0);
    check("async_font_addr", 16'(font_addr), 16'd0);
    check("async_pixel", 16'({pixel_valid, pixel_on}), 16'd0);
    check("async_ready", 16'(frame_ready), 16'd0);
    model_err = 1'b0;
    model_ready = 1'b0;
    tick();
    reset = 1'b0;
    wait_ready("reset_clear_len");
    scan_one(639, 479, fa, po, pv);
    check("post_reset_last", 16'(fa[8:4]), 16'd0);
    check("post_reset_err", 16'(wr_error), 16'(model_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
